xadc_aux_scan_ctrl: RTL

Sequences the XADC through the four auxiliary analog channels and publishes the latest 12-bit result of each as `MEASURED_AUX0`..`MEASURED_AUX3` for the AXI configuration register block. For each channel it drives the external analog multiplexer select, waits a programmable settling time and the next XADC end-of-conversion, then reads the channel's result register over the DRP port. A DRP-timeout guard and sticky error flag keep a missing XADC from stalling the scan.

---
 rtl/xadc_aux_scan_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/xadc_aux_scan_ctrl.sv
// Scans XADC VAUX0..3: drives the mux, waits for settle and EOC, reads each result over DRP into MEASURED_AUXk.
// A channel takes SETTLE_CYCLES+4 cycles with prompt responses; a missing EOC/DRDY times out and sets a sticky error.
module xadc_aux_scan_ctrl #(
  parameter int unsigned SETTLE_CYCLES  = 64,
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter logic [6:0]  DRP_BASE_ADDR  = 7'h10
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESETN,
  input  logic        scan_enable,
  input  logic        onehot_mux,
  input  logic        err_clr,
  input  logic        xadc_eoc,
  input  logic        drp_drdy,
  input  logic [15:0] drp_do,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [6:0]  drp_daddr,
  output logic [15:0] drp_di,
  output logic [3:0]  mux_sel,
  output logic [11:0] MEASURED_AUX0,
  output logic [11:0] MEASURED_AUX1,
  output logic [11:0] MEASURED_AUX2,
  output logic [11:0] MEASURED_AUX3,
  output logic        scan_done,
  output logic        busy,
  output logic        drp_timeout_err
);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    WAIT_EOC,
    DRP_REQ,
    DRP_WAIT,
    STORE
  } state_t;

  localparam logic [15:0] SETTLE_LOAD  = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  ch;
  logic [1:0]  ch_nxt;
  logic [15:0] settle_cnt;
  logic [15:0] wait_cnt;
  logic        to_hit;
  logic        store_en;
  logic        set_err;
  logic        unused_drp_lsbs;

  assign drp_dwe         = 1'b0;
  assign drp_di          = 16'h0000;
  assign unused_drp_lsbs = ^drp_do[3:0];
  assign to_hit          = (wait_cnt == TIMEOUT_LAST);

  // Held for the whole channel so the XADC keeps converting the selected input.
  always_comb begin
    mux_sel = 4'b0000;
    if (state != IDLE) begin
      mux_sel = onehot_mux ? (4'b0001 << ch) : {2'b00, ch};
    end
  end

  always_comb begin
    state_nxt = state;
    ch_nxt    = ch;
    store_en  = 1'b0;
    set_err   = 1'b0;
    case (state)
      IDLE: begin
        ch_nxt = 2'd0;
        if (scan_enable) state_nxt = SETTLE;
      end
      SETTLE: begin
        // EOCs seen here belong to the previous channel and are dropped.
        if (settle_cnt == 16'd0) state_nxt = WAIT_EOC;
      end
      WAIT_EOC: begin
        if (xadc_eoc) begin
          state_nxt = DRP_REQ;
        end else if (to_hit) begin
          set_err   = 1'b1;
          state_nxt = STORE;
        end
      end
      DRP_REQ: begin
        state_nxt = DRP_WAIT;
      end
      DRP_WAIT: begin
        if (drp_drdy) begin
          store_en  = 1'b1;
          state_nxt = STORE;
        end else if (to_hit) begin
          set_err   = 1'b1;
          state_nxt = STORE;
        end
      end
      STORE: begin
        if (scan_enable) begin
          ch_nxt    = ch + 2'd1;
          state_nxt = SETTLE;
        end else begin
          ch_nxt    = 2'd0;
          state_nxt = IDLE;
        end
      end
      default: begin
        ch_nxt    = 2'd0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state           <= IDLE;
      ch              <= 2'd0;
      settle_cnt      <= 16'd0;
      wait_cnt        <= 16'd0;
      drp_den         <= 1'b0;
      drp_daddr       <= 7'd0;
      scan_done       <= 1'b0;
      busy            <= 1'b0;
      drp_timeout_err <= 1'b0;
      MEASURED_AUX0   <= 12'd0;
      MEASURED_AUX1   <= 12'd0;
      MEASURED_AUX2   <= 12'd0;
      MEASURED_AUX3   <= 12'd0;
    end else begin
      state <= state_nxt;
      ch    <= ch_nxt;

      if (state != SETTLE) begin
        settle_cnt <= SETTLE_LOAD;
      end else if (settle_cnt != 16'd0) begin
        settle_cnt <= settle_cnt - 16'd1;
      end

      if (state_nxt != state) begin
        wait_cnt <= 16'd0;
      end else if (state == WAIT_EOC || state == DRP_WAIT) begin
        wait_cnt <= wait_cnt + 16'd1;
      end

      // Registered from next-state so these line up with the state they describe.
      drp_den   <= (state_nxt == DRP_REQ);
      drp_daddr <= (state_nxt == DRP_REQ) ? (DRP_BASE_ADDR + 7'(ch)) : 7'd0;
      scan_done <= (state_nxt == STORE) && (ch == 2'd3);
      busy      <= (state_nxt != IDLE);

      if (set_err) begin
        drp_timeout_err <= 1'b1;
      end else if (err_clr) begin
        drp_timeout_err <= 1'b0;
      end

      if (store_en) begin
        case (ch)
          2'd0:    MEASURED_AUX0 <= drp_do[15:4];
          2'd1:    MEASURED_AUX1 <= drp_do[15:4];
          2'd2:    MEASURED_AUX2 <= drp_do[15:4];
          default: MEASURED_AUX3 <= drp_do[15:4];
        endcase
      end
    end
  end

endmodule
